// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types, FSM encoding and GF(2^8) helpers for the sequenced
// MixColumns engine.
//   aes_state_t : 128-bit AES state, column c at [127-32c -: 32]
//   aes_col_t   : one 32-bit column, row r at [31-8r -: 8]
//   aes_byte_t  : one GF(2^8) element
//   mc_state_t  : controller states IDLE / BUSY / DONE
//   xtime       : multiply by x (02) modulo x^8+x^4+x^3+x+1
//   gf_mul      : general GF(2^8) multiply built from xtime
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // Low byte of the reduction polynomial 0x11B; bit 8 is implied by the shift.
  localparam aes_byte_t GF_POLY = 8'h1B;

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b the unused partial
  // products disappear, so each call reduces to a small XOR network.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// ---------------------------------------------------------------------------
// mix_single_column
// Purely combinational MixColumns transform of one 32-bit column.
// Ports:
//   inv     : in  1   select InvMixColumns (only with AES_INV_MIXCOL_EN)
//   col_in  : in  32  column, row 0 in bits [31:24]
//   col_out : out 32  mixed column, same byte layout
// Macro AES_INV_MIXCOL_EN adds the inverse matrix and the inv select;
// without it only the forward matrix is built.
// ---------------------------------------------------------------------------
module mix_single_column
  import aes_pkg::*;
(
`ifdef AES_INV_MIXCOL_EN
  input  logic     inv,
`endif
  input  aes_col_t col_in,
  output aes_col_t col_out
);

  aes_byte_t a0, a1, a2, a3;
  aes_col_t  fwd_col;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Forward rows {02 03 01 01} rotated right per row; 03*a = xtime(a)^a.
  always_comb begin
    fwd_col         = '0;
    fwd_col[31:24]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    fwd_col[23:16]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    fwd_col[15:8]   = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    fwd_col[7:0]    = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

`ifdef AES_INV_MIXCOL_EN
  aes_col_t inv_col;

  // Inverse rows {0e 0b 0d 09} rotated the same way.
  always_comb begin
    inv_col        = '0;
    inv_col[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    inv_col[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    inv_col[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    inv_col[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  assign col_out = inv ? inv_col : fwd_col;
`else
  assign col_out = fwd_col;
`endif

endmodule

// File: rtl/mixcolumns_ctrl.sv
// ---------------------------------------------------------------------------
// mixcolumns_ctrl
// Sequenced MixColumns engine: accepts a 128-bit state, mixes one column
// per cycle through a single shared column unit, then presents the result.
// Ports:
//   clk         : in  1    rising-edge clock
//   rst_n       : in  1    asynchronous active-low reset
//   in_valid    : in  1    input state presented
//   in_ready    : out 1    block can accept a state this cycle
//   state       : in  128  input state (column c at [127-32c -: 32])
//   out_valid   : out 1    mixed state available
//   out_ready   : in  1    downstream accepts outputstate
//   outputstate : out 128  mixed state, same layout as the input
//   busy        : out 1    high while columns are being processed
//   inv_mode    : in  1    InvMixColumns select (only with AES_INV_MIXCOL_EN)
// Macro AES_INV_MIXCOL_EN enables the inv_mode port and inverse datapath.
// ---------------------------------------------------------------------------
module mixcolumns_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outputstate,
`ifdef AES_INV_MIXCOL_EN
  input  logic         inv_mode,
`endif
  output logic         busy
);

  mc_state_t  fsm;
  logic [1:0] col_cnt;
  aes_state_t work;
  aes_col_t   cur_col;
  aes_col_t   mixed_col;

`ifdef AES_INV_MIXCOL_EN
  logic inv_q;
`endif

  // Accepting in DONE overlaps the output handshake with the next capture.
  assign in_ready    = (fsm == IDLE) | ((fsm == DONE) & out_ready);
  assign outputstate = work;

  always_comb begin
    cur_col = work[127:96];
    case (col_cnt)
      2'd0:    cur_col = work[127:96];
      2'd1:    cur_col = work[95:64];
      2'd2:    cur_col = work[63:32];
      default: cur_col = work[31:0];
    endcase
  end

  mix_single_column u_col (
`ifdef AES_INV_MIXCOL_EN
    .inv     (inv_q),
`endif
    .col_in  (cur_col),
    .col_out (mixed_col)
  );

  // Single FSM block; busy and out_valid are registered alongside the state
  // so they change exactly on the transition edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      col_cnt   <= 2'd0;
      work      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef AES_INV_MIXCOL_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            work    <= state;
            col_cnt <= 2'd0;
`ifdef AES_INV_MIXCOL_EN
            inv_q   <= inv_mode;
`endif
            fsm     <= BUSY;
            busy    <= 1'b1;
          end
        end
        BUSY: begin
          case (col_cnt)
            2'd0:    work[127:96] <= mixed_col;
            2'd1:    work[95:64]  <= mixed_col;
            2'd2:    work[63:32]  <= mixed_col;
            default: work[31:0]   <= mixed_col;
          endcase
          // Wraps 3 -> 0 on the final column, ready for the next block.
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            fsm       <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work    <= state;
              col_cnt <= 2'd0;
`ifdef AES_INV_MIXCOL_EN
              inv_q   <= inv_mode;
`endif
              fsm     <= BUSY;
              busy    <= 1'b1;
            end else begin
              fsm <= IDLE;
            end
          end
        end
        default: begin
          fsm       <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
